sj_seq_alu: RTL and testbench

SJ_SEQ_ALU -- requirements
Module: sj_seq_alu

---
 rtl/sj_seq_alu_if.sv | 30 +++
 rtl/sj_seq_alu.sv | 153 +++++++++++++++
 tb/tb_sj_seq_alu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sj_seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : sj_seq_alu_if
// Brief    : Operand/command and result bundle for the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface sj_seq_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] readA;
    logic [WIDTH-1:0] readB;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] write;
    logic             carry;
    logic             zero;

    modport master (
        output readA, readB, op, start,
        input  busy, done, write, carry, zero
    );

    modport slave (
        input  readA, readB, op, start,
        output busy, done, write, carry, zero
    );
endinterface
`default_nettype wire

// File: rtl/sj_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : sj_seq_alu
// Brief    : Sequential ALU: single-cycle ops plus an iterative shift-add MUL.
// Revision : 1.0 - initial release
// ============================================================================
module sj_seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   RST,
    sj_seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;
    localparam logic [2:0] c_OP_ACC = 3'b110;
    localparam logic [2:0] c_OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_mul_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH-1:0]   r_write;
    logic               r_carry;
    logic               r_zero;
    logic               r_done;
    logic               r_busy;

    logic [WIDTH:0]     w_alu;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_last   = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = (bus.op == c_OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC:  w_state_next = S_IDLE;
            S_MUL:   if (w_mul_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------- single-cycle ALU
    // Bit WIDTH carries carry-out, borrow, or the last bit shifted out.
    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_ADD: w_alu = {1'b0, r_a} + {1'b0, r_b};
            c_OP_SUB: w_alu = {1'b0, r_a} - {1'b0, r_b};
            c_OP_AND: w_alu = {1'b0, r_a & r_b};
            c_OP_OR:  w_alu = {1'b0, r_a | r_b};
            c_OP_XOR: w_alu = {1'b0, r_a ^ r_b};
            c_OP_ACC: w_alu = {1'b0, r_write} + {1'b0, r_a};
            c_OP_SHL: w_alu = {1'b0, r_a} << r_b[SHW-1:0];
            default:  w_alu = '0;
        endcase
    end

    // Shift-add step: multiplier sits in the low half and drains out the right.
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
        w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_write <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_next != S_IDLE);

            if (w_accept) begin
                r_a    <= bus.readA;
                r_b    <= bus.readB;
                r_op   <= bus.op;
                r_cnt  <= '0;
                r_prod <= {{WIDTH{1'b0}}, bus.readB};
            end

            if (r_state == S_EXEC) begin
                r_write <= w_alu[WIDTH-1:0];
                r_carry <= w_alu[WIDTH];
                r_zero  <= (w_alu[WIDTH-1:0] == '0);
                r_done  <= 1'b1;
            end

            if (r_state == S_MUL) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_write <= w_prod_next[WIDTH-1:0];
                    r_carry <= |w_prod_next[2*WIDTH-1:WIDTH];
                    r_zero  <= (w_prod_next[WIDTH-1:0] == '0);
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.write = r_write;
    assign bus.carry = r_carry;
    assign bus.zero  = r_zero;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sj_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_sj_seq_alu
// Brief    : Self-checking bench for sj_seq_alu against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sj_seq_alu;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] model_write;

    sj_seq_alu_if #(.WIDTH(W)) bus ();

    sj_seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {carry, result} straight from the operation definitions.
    function automatic logic [W:0] model(input logic [2:0] op, input int a, input int b, input int acc);
        int   r;
        int   s;
        logic c;
        c = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = a + b;   c = (r > 255); end
            3'd1: begin r = a - b;   c = (a < b);   end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a * b;   c = (r > 255); end
            3'd6: begin r = acc + a; c = (r > 255); end
            default: begin
                s = b % W;
                r = a << s;
                c = (s != 0) ? ((a >> (W - s)) & 1) != 0 : 1'b0;
            end
        endcase
        return {c, r[W-1:0]};
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done was seen.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] m;
        int   exp_lat;
        int   n_busy;
        int   k;
        logic seen;
        m       = model(op, int'(a), int'(b), int'(model_write));
        exp_lat = (op == 3'b101) ? W + 1 : 2;
        bus.start = 1'b1;
        bus.op    = op;
        bus.readA = a;
        bus.readB = b;
        n_busy = 0;
        seen   = 1'b0;
        k      = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            k = c;
            if (bus.done) begin
                seen = 1'b1;
            end else if (bus.busy) begin
                n_busy++;
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 3'($urandom_range(0, 7));
                bus.readA = W'($urandom_range(0, 255));
                bus.readB = W'($urandom_range(0, 255));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("done_seen",    {31'd0, seen}, 32'd1);
        check("latency",      k, exp_lat);
        check("busy_cycles",  n_busy, exp_lat - 1);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("write",        {24'd0, bus.write}, {24'd0, m[W-1:0]});
        check("carry",        {31'd0, bus.carry}, {31'd0, m[W]});
        check("zero",         {31'd0, bus.zero}, {31'd0, (m[W-1:0] == '0)});
        model_write = m[W-1:0];
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("no_stray_done", {31'd0, bus.done}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_write = '0;
        check("rst_write", {24'd0, bus.write}, 32'd0);
        check("rst_carry", {31'd0, bus.carry}, 32'd0);
        check("rst_zero",  {31'd0, bus.zero},  32'd1);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_write = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.readA = '0;
        bus.readB = '0;
        @(negedge clk);
        do_reset();

        // Directed cases
        run_op(3'b000, 8'd200, 8'd100);
        check("add_const", {24'd0, bus.write}, 32'h2C);
        idle_cycles(1);
        run_op(3'b001, 8'd5, 8'd7);
        run_op(3'b101, 8'd13, 8'd11);
        check("mul_const", {24'd0, bus.write}, 32'h8F);
        run_op(3'b101, 8'd16, 8'd16);
        idle_cycles(2);

        do_reset();
        for (int i = 0; i < 3; i++) run_op(3'b110, 8'h60, 8'h00);
        check("acc_const", {24'd0, bus.write}, 32'h20);
        idle_cycles(1);

        // Random mix of back-to-back and gapped operations
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        // Reset during the 4th MUL cycle aborts with no done pulse
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.readA = 8'd13;
        bus.readB = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_pre_rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_write = '0;
        check("abort_busy",  {31'd0, bus.busy},  32'd0);
        check("abort_write", {24'd0, bus.write}, 32'd0);
        check("abort_zero",  {31'd0, bus.zero},  32'd1);
        check("abort_done",  {31'd0, bus.done},  32'd0);
        idle_cycles(12);
        run_op(3'b111, 8'h81, 8'h01);
        check("shl_const", {24'd0, bus.write}, 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
